// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the MEM stage.
// Serialises requests, returns registered read data with a one-cycle ready pulse, and stalls the pipeline.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ready,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {REQ_IF, REQ_DM} req_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    req_t                  last_grant, owner, owner_next, grant;
    logic                  dm_req, issue, issue_write, capture;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign dm_req  = dm_read | dm_write;
    assign issue   = (state == IDLE) && !reset && (if_req || dm_req);
    assign capture = (state == WAIT) && (cnt == 4'd0);

    // On a conflict the requester that lost last time wins; a lone requester always wins.
    assign grant = (if_req && dm_req) ? ((last_grant == REQ_IF) ? REQ_DM : REQ_IF)
                 : (dm_req ? REQ_DM : REQ_IF);

    // Read+write together is treated as a write.
    assign issue_write = issue && (grant == REQ_DM) && dm_write;
    assign owner_next  = issue ? grant : owner;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (issue) begin
                    if (issue_write) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(MEM_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_en    = issue;
    assign mem_we    = issue_write;
    assign mem_addr  = issue ? ((grant == REQ_DM) ? dm_addr : if_addr) : addr_q;
    assign mem_wdata = issue_write ? dm_wdata : wdata_q;

    assign stall = !reset && ((if_req && !if_ready) || (dm_req && !dm_ready));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= REQ_IF;
            owner      <= REQ_IF;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err        <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            owner    <= owner_next;
            // Ready is registered so it lines up with the RESP cycle.
            if_ready <= (state_next == RESP) && (owner_next == REQ_IF);
            dm_ready <= (state_next == RESP) && (owner_next == REQ_DM);
            if (issue) begin
                last_grant <= grant;
                addr_q     <= mem_addr;
            end
            if (issue_write) wdata_q <= dm_wdata;
            if (capture && owner == REQ_IF) if_rdata <= mem_rdata;
            if (capture && owner == REQ_DM) dm_rdata <= mem_rdata;
            if (dm_read && dm_write) err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch stage and the MEM stage of the pipelined MIPS datapath. It serialises requests onto the memory port, returns read data to the winning requester with a one-cycle ready pulse, and raises a pipeline stall while any request is outstanding. Memory read latency is fixed and set by a parameter. The memory port has no handshake of its own.

## Interface
- MEM_LATENCY, 2, cycles from the issue cycle to `mem_rdata` being valid; legal range 1..15
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request; held with `if_addr` until `if_ready`
- if_addr  in  ADDR_WIDTH  fetch address (the PC)
- if_ready  out  1  one-cycle pulse; `if_rdata` is valid in that cycle
- if_rdata  out  DATA_WIDTH  fetched instruction, registered
- dm_read  in  1  data read request; held until `dm_ready`
- dm_write  in  1  data write request; held until `dm_ready`
- dm_addr  in  ADDR_WIDTH  data address (ALU result)
- dm_wdata  in  DATA_WIDTH  store data
- dm_ready  out  1  one-cycle completion pulse for a read or a write
- dm_rdata  out  DATA_WIDTH  load data, registered
- mem_en  out  1  memory access strobe, high for exactly the issue cycle
- mem_we  out  1  write strobe, high only with `mem_en`
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid in cycle t+MEM_LATENCY for an issue in cycle t
- stall  out  1  freezes PC, IF/ID and all later pipeline registers
- err  out  1  sticky protocol error flag

## Operation
- States:
  - IDLE: no transaction in flight.
  - WAIT: read in flight; counter `cnt` runs.
  - RESP: ready pulse is out.
- The arbiter issues in cycle t when it is in IDLE, reset is low, and at least one request is present.
- Issue-cycle outputs are combinational from the state and the granted requester: `mem_en`=1, plus `mem_addr`, `mem_we` and `mem_wdata`.
  - When no issue occurs, `mem_en`=0 and `mem_we`=0.
  - `mem_addr` and `mem_wdata` then hold the last issued values.
- Grant rule:
  - With a single requester, that requester wins.
  - When both request, the requester not granted last wins.
  - `last_grant` resets to IF, so the first conflict goes to DM (the older instruction).
- Read transaction:
  - IDLE→WAIT at the issue edge; `cnt` is loaded with MEM_LATENCY-1.
  - In WAIT with `cnt`==0: capture `mem_rdata` into the winner's rdata register, go to RESP.
  - In WAIT with `cnt`≠0: decrement `cnt`.
- Write transaction: IDLE→RESP at the issue edge. Memory commits the write on that edge.
- RESP:
  - Raise the winner's ready for one cycle, then go to IDLE.
  - No issue occurs in RESP, because the requester still presents the completed request.
- `dm_read` and `dm_write` both high: treat as a write and set `err`. `err` clears only on reset.
- A request dropped mid-transaction does not cancel it. The transaction completes and the ready pulse still fires.
- `stall` = (`if_req` & ~`if_ready`) | ((`dm_read`|`dm_write`) & ~`dm_ready`), forced to 0 while reset is high.
- `if_rdata` and `dm_rdata` hold their value until the next capture for the same requester.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `last_grant`=IF.
  - `if_ready`, `dm_ready`, `err` = 0.
  - `if_rdata`, `dm_rdata` = 0; `mem_addr`, `mem_wdata` = 0.
  - `mem_en`, `mem_we` = 0 in every cycle reset is high, regardless of requests.
- Read latency: issue at t, capture at the end of t+MEM_LATENCY, ready at t+MEM_LATENCY+1. Next issue no earlier than t+MEM_LATENCY+2.
- Write latency: issue at t, ready at t+1. Next issue no earlier than t+2.
- Reset during WAIT or RESP:
  - Go to IDLE on that edge and discard the in-flight data; no ready pulse follows.
  - The first issue is possible in the first cycle with reset low.
- Simultaneous new request and RESP: the request waits. It issues in the following IDLE cycle under the grant rule.

## Test plan
- MEM_LATENCY=2, `if_req` at t with `if_addr`=0x00000010; model returns 0x8C010004 at t+2.
  - Required: `mem_en`=1 only at t; `if_ready`=1 only at t+3 with `if_rdata`=0x8C010004.
  - Required: `stall`=1 for t..t+2, 0 at t+3.
- `if_req` plus `dm_read` (addr 0x40) in the same cycle t after reset.
  - Required: DM issued at t, `dm_ready` at t+3.
  - Required: IF issued at t+4, `if_ready` at t+7.
- `dm_write` at t with addr 0x40, data 0xDEADBEEF.
  - Required: `mem_en`=`mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0xDEADBEEF at t.
  - Required: `dm_ready` at t+1; a subsequent read of 0x40 returns 0xDEADBEEF.
- Both requesters held continuously across four transactions.
  - Required: grant order DM, IF, DM, IF; issue cycles t, t+4, t+8, t+12.
- `dm_read` issued at t, `reset` high at t+1.
  - Required: all outputs 0 at t+2 and no `dm_ready` pulse.
  - Required: a request held after reset deasserts issues in the first cycle with reset low.
- MEM_LATENCY=1 build: read issued at t gives ready at t+2. Then `dm_read` and `dm_write` together give a write, `err`=1, and `err` stays high until reset.
